// File: rtl/brpred_if.sv
// Fetch/execute side connection of the branch predictor: IF lookup, EX training feedback,
// flush redirect and statistics.
interface brpred_if;
   logic [31:0] pc_i;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic [31:0] upd_pred_target_i;
   logic        mispred_o;
   logic [31:0] redirect_pc_o;
   logic [31:0] br_cnt_o;
   logic [31:0] mispred_cnt_o;

   modport master (
      output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
             upd_pred_taken_i, upd_pred_target_i,
      input  pred_taken_o, pred_target_o, mispred_o, redirect_pc_o,
             br_cnt_o, mispred_cnt_o
   );

   modport slave (
      input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
             upd_pred_taken_i, upd_pred_target_i,
      output pred_taken_o, pred_target_o, mispred_o, redirect_pc_o,
             br_cnt_o, mispred_cnt_o
   );
endinterface

// File: rtl/brpred_pipeline.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained from EX-stage
// outcomes, with mispredict detection and saturating statistics counters.
module brpred_pipeline #(
   parameter int ENTRIES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   brpred_if.slave bp
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic [31:0]      br_cnt_q;
   logic [31:0]      mispred_cnt_q;

   logic [IDX_W-1:0] look_idx;
   logic [TAG_W-1:0] look_tag;
   logic             look_hit;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             upd_accept;
   logic             mispred;
   logic [31:0]      redirect_pc;
   logic             unused_pc_bits;

   assign look_idx = bp.pc_i[IDX_W+1:2];
   assign look_tag = bp.pc_i[31:IDX_W+2];
   assign upd_idx  = bp.upd_pc_i[IDX_W+1:2];
   assign upd_tag  = bp.upd_pc_i[31:IDX_W+2];
   assign unused_pc_bits = ^{bp.pc_i[1:0], bp.upd_pc_i[1:0]};

   // Lookup reads registered state only, so a same-cycle update is seen one cycle later.
   assign look_hit         = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
   assign bp.pred_taken_o  = look_hit && ctr_q[look_idx][1];
   assign bp.pred_target_o = bp.pred_taken_o ? target_q[look_idx] : bp.pc_i + 32'd4;

   assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign upd_accept  = bp.upd_valid_i && !rst_i;
   assign redirect_pc = bp.upd_taken_i ? bp.upd_target_i : bp.upd_pc_i + 32'd4;
   assign mispred     = upd_accept &&
                        ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
                         (bp.upd_pred_target_i != redirect_pc));

   assign bp.mispred_o     = mispred;
   assign bp.redirect_pc_o = redirect_pc;
   assign bp.br_cnt_o      = br_cnt_q;
   assign bp.mispred_cnt_o = mispred_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (upd_accept) begin
         if (upd_hit) begin
            if (bp.upd_taken_i) begin
               if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
               target_q[upd_idx] <= bp.upd_target_i;
            end else if (ctr_q[upd_idx] != 2'b00) begin
               ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
            end
         end else if (bp.upd_taken_i) begin
            // A taken miss claims the slot outright, evicting any aliasing branch.
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= bp.upd_target_i;
            ctr_q[upd_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (upd_accept && br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
         if (mispred && mispred_cnt_q != 32'hFFFF_FFFF) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_brpred_pipeline.sv
// Directed self-checking bench for brpred_pipeline with hand-computed expectations.
module tb_brpred_pipeline;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   brpred_if bp ();

   brpred_pipeline #(.ENTRIES(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bp    (bp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic ptaken, input logic [31:0] ptgt);
      bp.upd_valid_i       = 1'b1;
      bp.upd_pc_i          = pc;
      bp.upd_taken_i       = taken;
      bp.upd_target_i      = tgt;
      bp.upd_pred_taken_i  = ptaken;
      bp.upd_pred_target_i = ptgt;
   endtask

   task automatic test_reset();
      bp.pc_i = 32'h100;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken got %0b want 0", bp.pred_taken_o); end
      checks++;
      if (bp.pred_target_o !== 32'h104) begin errors++; $display("[TB] FAIL reset_target got %h want 00000104", bp.pred_target_o); end
      checks++;
      if (bp.br_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_brcnt got %0d want 0", bp.br_cnt_o); end
      checks++;
      if (bp.mispred_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_miscnt got %0d want 0", bp.mispred_cnt_o); end
   endtask

   task automatic test_allocate();
      drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
      #1;
      checks++;
      if (bp.mispred_o !== 1'b1) begin errors++; $display("[TB] FAIL alloc_mispred got %0b want 1", bp.mispred_o); end
      checks++;
      if (bp.redirect_pc_o !== 32'h200) begin errors++; $display("[TB] FAIL alloc_redirect got %h want 00000200", bp.redirect_pc_o); end
      step();
      bp.upd_valid_i = 1'b0;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b1 || bp.pred_target_o !== 32'h200) begin
         errors++; $display("[TB] FAIL alloc_lookup got %0b/%h want 1/00000200", bp.pred_taken_o, bp.pred_target_o);
      end
      checks++;
      if (bp.br_cnt_o !== 32'd1 || bp.mispred_cnt_o !== 32'd1) begin
         errors++; $display("[TB] FAIL alloc_counts got %0d/%0d want 1/1", bp.br_cnt_o, bp.mispred_cnt_o);
      end
      checks++;
      if (bp.mispred_o !== 1'b0 || bp.redirect_pc_o !== 32'h200) begin
         errors++; $display("[TB] FAIL idle_redirect got %0b/%h want 0/00000200", bp.mispred_o, bp.redirect_pc_o);
      end
   endtask

   task automatic test_hysteresis();
      drive_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
      #1;
      checks++;
      if (bp.mispred_o !== 1'b1 || bp.redirect_pc_o !== 32'h104) begin
         errors++; $display("[TB] FAIL hyst_nt_mispred got %0b/%h want 1/00000104", bp.mispred_o, bp.redirect_pc_o);
      end
      step();
      bp.upd_valid_i = 1'b0;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 32'h104) begin
         errors++; $display("[TB] FAIL hyst_weak_nt got %0b/%h want 0/00000104", bp.pred_taken_o, bp.pred_target_o);
      end
      drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
      step();
      drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      #1;
      checks++;
      if (bp.mispred_o !== 1'b0) begin errors++; $display("[TB] FAIL hyst_correct_pred got %0b want 0", bp.mispred_o); end
      step();
      step();
      drive_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
      step();
      bp.upd_valid_i = 1'b0;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b1 || bp.pred_target_o !== 32'h200) begin
         errors++; $display("[TB] FAIL hyst_sat_taken got %0b/%h want 1/00000200", bp.pred_taken_o, bp.pred_target_o);
      end
      checks++;
      if (bp.br_cnt_o !== 32'd6 || bp.mispred_cnt_o !== 32'd4) begin
         errors++; $display("[TB] FAIL hyst_counts got %0d/%0d want 6/4", bp.br_cnt_o, bp.mispred_cnt_o);
      end
   endtask

   task automatic test_aliasing();
      drive_upd(32'h140, 1'b0, 32'h300, 1'b0, 32'h144);
      #1;
      checks++;
      if (bp.mispred_o !== 1'b0) begin errors++; $display("[TB] FAIL alias_nt_mispred got %0b want 0", bp.mispred_o); end
      step();
      bp.upd_valid_i = 1'b0;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b1 || bp.pred_target_o !== 32'h200) begin
         errors++; $display("[TB] FAIL alias_no_evict got %0b/%h want 1/00000200", bp.pred_taken_o, bp.pred_target_o);
      end
      drive_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
      step();
      bp.upd_valid_i = 1'b0;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 32'h104) begin
         errors++; $display("[TB] FAIL alias_evicted got %0b/%h want 0/00000104", bp.pred_taken_o, bp.pred_target_o);
      end
      bp.pc_i = 32'h140;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b1 || bp.pred_target_o !== 32'h300) begin
         errors++; $display("[TB] FAIL alias_new_entry got %0b/%h want 1/00000300", bp.pred_taken_o, bp.pred_target_o);
      end
      checks++;
      if (bp.br_cnt_o !== 32'd8 || bp.mispred_cnt_o !== 32'd5) begin
         errors++; $display("[TB] FAIL alias_counts got %0d/%0d want 8/5", bp.br_cnt_o, bp.mispred_cnt_o);
      end
   endtask

   task automatic test_same_cycle();
      bp.pc_i = 32'h100;
      drive_upd(32'h100, 1'b1, 32'h400, 1'b0, 32'h104);
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 32'h104) begin
         errors++; $display("[TB] FAIL hazard_old got %0b/%h want 0/00000104", bp.pred_taken_o, bp.pred_target_o);
      end
      step();
      bp.upd_valid_i = 1'b0;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b1 || bp.pred_target_o !== 32'h400) begin
         errors++; $display("[TB] FAIL hazard_new got %0b/%h want 1/00000400", bp.pred_taken_o, bp.pred_target_o);
      end
   endtask

   task automatic test_wrap();
      bp.pc_i             = 32'hFFFF_FFFC;
      bp.upd_valid_i      = 1'b0;
      bp.upd_pc_i         = 32'hFFFF_FFFC;
      bp.upd_taken_i      = 1'b0;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 32'h0) begin
         errors++; $display("[TB] FAIL wrap_target got %0b/%h want 0/00000000", bp.pred_taken_o, bp.pred_target_o);
      end
      checks++;
      if (bp.redirect_pc_o !== 32'h0 || bp.mispred_o !== 1'b0) begin
         errors++; $display("[TB] FAIL wrap_redirect got %h/%0b want 00000000/0", bp.redirect_pc_o, bp.mispred_o);
      end
   endtask

   task automatic test_saturation();
      step();
      force dut.mispred_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.mispred_cnt_q;
      drive_upd(32'h200, 1'b1, 32'h500, 1'b0, 32'h204);
      step();
      bp.upd_valid_i = 1'b0;
      #1;
      checks++;
      if (bp.mispred_cnt_o !== 32'hFFFF_FFFF) begin
         errors++; $display("[TB] FAIL sat_miscnt got %h want ffffffff", bp.mispred_cnt_o);
      end
      checks++;
      if (bp.br_cnt_o !== 32'd10) begin errors++; $display("[TB] FAIL sat_brcnt got %0d want 10", bp.br_cnt_o); end
   endtask

   task automatic test_reset_update();
      rst = 1'b1;
      drive_upd(32'h180, 1'b1, 32'h600, 1'b0, 32'h184);
      #1;
      checks++;
      if (bp.mispred_o !== 1'b0) begin errors++; $display("[TB] FAIL rstupd_mispred got %0b want 0", bp.mispred_o); end
      step();
      rst = 1'b0;
      bp.upd_valid_i = 1'b0;
      bp.pc_i = 32'h180;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 32'h184) begin
         errors++; $display("[TB] FAIL rstupd_lookup got %0b/%h want 0/00000184", bp.pred_taken_o, bp.pred_target_o);
      end
      bp.pc_i = 32'h140;
      #1;
      checks++;
      if (bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 32'h144) begin
         errors++; $display("[TB] FAIL rstupd_forgot got %0b/%h want 0/00000144", bp.pred_taken_o, bp.pred_target_o);
      end
      checks++;
      if (bp.br_cnt_o !== 32'd0 || bp.mispred_cnt_o !== 32'd0) begin
         errors++; $display("[TB] FAIL rstupd_counts got %0d/%0d want 0/0", bp.br_cnt_o, bp.mispred_cnt_o);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bp.pc_i = 32'h0;
      bp.upd_valid_i = 1'b0;
      bp.upd_pc_i = 32'h0;
      bp.upd_taken_i = 1'b0;
      bp.upd_target_i = 32'h0;
      bp.upd_pred_taken_i = 1'b0;
      bp.upd_pred_target_i = 32'h0;
      step();
      step();
      rst = 1'b0;
      test_reset();
      test_allocate();
      test_hysteresis();
      test_aliasing();
      test_same_cycle();
      test_wrap();
      test_saturation();
      test_reset_update();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/brpred_pipeline.md
Name: brpred_pipeline

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) plus 2-bit saturating counters.
- The IF stage looks up pc_i and gets a predicted direction and target.
- The EX stage sends back the resolved outcome produced by the branch comparator (its br_sel result) and the resolved target.
- The block trains its tables from that outcome, flags mispredictions with a redirect PC for pipeline flush, and keeps branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16, number of BTB/counter entries; power of two, >= 2.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridable).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- pc_i  input  32  IF-stage PC to predict.
- pred_taken_o  output  1  predicted taken for pc_i.
- pred_target_o  output  32  predicted next PC for pc_i.
- upd_valid_i  input  1  EX stage holds a resolved control-transfer instruction this cycle.
- upd_pc_i  input  32  PC of the resolved instruction.
- upd_taken_i  input  1  resolved direction (branch comparator br_sel).
- upd_target_i  input  32  resolved taken target.
- upd_pred_taken_i  input  1  prediction made for this instruction at fetch, carried down the pipe.
- upd_pred_target_i  input  32  predicted next PC carried down the pipe.
- mispred_o  output  1  resolved outcome differs from prediction; flush.
- redirect_pc_o  output  32  correct next PC when mispred_o=1.
- br_cnt_o  output  32  resolved control transfers counted.
- mispred_cnt_o  output  32  mispredictions counted.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - pc[1:0] is ignored (4-byte instructions only).
- Storage per entry: valid (1 bit), tag, target (32 bits), ctr (2 bits).
- Reset (rst_i=1 at a clock edge):
  - all valid bits cleared, all ctr set to 2'b01, both statistics counters cleared.
  - Any update presented in the same cycle as rst_i is ignored.
- Lookup (combinational from registered state, 0-cycle latency):
  - hit = valid[index] && tag[index]==tag(pc_i).
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = pred_taken_o ? target[index] : pc_i+4, with wrap mod 2^32.
  - After reset: pred_taken_o=0 and pred_target_o=pc_i+4.
- Update, registered, on the edge where upd_valid_i=1 and rst_i=0:
  - Hit and taken: ctr increments, saturating at 2'b11; target overwritten with upd_target_i.
  - Hit and not taken: ctr decrements, saturating at 2'b00; target unchanged.
  - Miss and taken: allocate and overwrite the entry: valid=1, tag, target=upd_target_i, ctr=2'b10.
  - Miss and not taken: no table change.
- Same-cycle lookup and update to the same index:
  - lookup returns pre-update contents; no bypass.
  - The new contents are visible from the next cycle.
- Mispredict detection (combinational on update inputs):
  - mispred_o = upd_valid_i && !rst_i && (upd_pred_taken_i != upd_taken_i || upd_pred_target_i != redirect_pc_o).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - When upd_valid_i=0, mispred_o=0 and redirect_pc_o still follows the formula.
- Statistics counters (registered):
  - br_cnt_o += 1 on each accepted update.
  - mispred_cnt_o += 1 when mispred_o=1 at the edge.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Reset takes priority over everything. A reset in the middle of a training sequence discards all learned state.

Test Plan:
- Reset, then pc_i=32'h0000_0100 -> pred_taken_o=0, pred_target_o=32'h0000_0104, br_cnt_o=0, mispred_cnt_o=0.
- Update pc=32'h100, taken, target=32'h200, pred_taken=0, pred_target=32'h104:
  - mispred_o=1, redirect_pc_o=32'h200 in the same cycle.
  - Next cycle, lookup 32'h100 -> pred_taken_o=1, pred_target_o=32'h200; mispred_cnt_o=1, br_cnt_o=1.
- Hysteresis after the allocation above (ctr=2'b10):
  - one not-taken update -> ctr=2'b01, lookup predicts not taken;
  - then 3 taken updates -> ctr saturates at 2'b11;
  - one not-taken -> still predicts taken.
- Aliasing with ENTRIES=16: pc 32'h100 and 32'h140 share index 0 with different tags.
  - Taken update of 32'h140 evicts the 32'h100 entry -> lookup of 32'h100 gives pred_taken_o=0, pred_target_o=32'h104.
  - A not-taken miss does not evict.
- Same-cycle hazard: lookup and taken update to the same PC in the same cycle -> old prediction that cycle, new prediction the next cycle.
- Wrap and saturation checks:
  - pc_i=32'hFFFF_FFFC, not taken -> pred_target_o=32'h0000_0000.
  - Force mispred_cnt_o to all-ones, then one more mispredict -> value holds at 32'hFFFF_FFFF.
  - Assert rst_i in the same cycle as an update -> no table or counter change.
